uart_duplex: RTL and testbench

Parametrised full-duplex UART: one transmitter and one receiver sharing a single clock domain, with internal baud generation.
Supports configurable data width, optional odd/even parity, one or two stop bits and configurable oversampling.
Reports per-frame parity and framing errors.
Sits between the board serial pins and byte-stream consumers (console, debug loaders); a drop-in replacement for the existing fixed 8N1 TX/RX pair.

---
 rtl/uart_duplex.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_duplex.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_duplex.sv
// Full-duplex UART: frame-register transmitter plus oversampling receiver in one
// clock domain, reporting parity and framing errors for every received frame.
module uart_duplex #(
    parameter int unsigned DIVISOR    = 25,
    parameter int unsigned OVERSAMPLE = 4,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int unsigned BIT_CYC    = DIVISOR * OVERSAMPLE;
    localparam int unsigned PAR_BITS   = (PARITY != 0) ? 1 : 0;
    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int unsigned CYC_W      = $clog2(BIT_CYC);
    localparam int unsigned FB_W       = $clog2(FRAME_BITS);
    localparam int unsigned DIV_W      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int unsigned PH_W       = $clog2(OVERSAMPLE);
    localparam int unsigned DB_W       = $clog2(DATA_BITS);

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    tx_state_e             tx_state_q, tx_state_d;
    logic [FRAME_BITS-1:0] tx_frame_q, tx_frame_d, tx_frame_load;
    logic [CYC_W-1:0]      tx_cyc_q, tx_cyc_d;
    logic [FB_W-1:0]       tx_bit_q, tx_bit_d;
    logic                  tx_q, tx_d, tx_ready_q, tx_ready_d;

    rx_state_e             rx_state_q, rx_state_d;
    logic [1:0]            rx_sync_q;
    logic                  rx_s;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  tick;
    logic [PH_W-1:0]       rx_phase_q, rx_phase_d;
    logic [DB_W-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
    logic                  rx_perr_q, rx_perr_d;
    logic                  rx_at_mid, rx_sample;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_perr_out_q, rx_perr_out_d;
    logic                  rx_ferr_q, rx_ferr_d;

    assign tx            = tx_q;
    assign tx_ready      = tx_ready_q;
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_parity_err = rx_perr_out_q;
    assign rx_frame_err  = rx_ferr_q;

    // Frame image, transmitted from bit 0: {stop bit(s), parity?, data, start}
    always_comb begin
        tx_frame_load                = '1;
        tx_frame_load[0]             = 1'b0;
        tx_frame_load[DATA_BITS:1]   = tx_data;
        if (PARITY == 1) begin
            tx_frame_load[DATA_BITS+1] = ~(^tx_data);
        end else if (PARITY == 2) begin
            tx_frame_load[DATA_BITS+1] = ^tx_data;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_frame_d = tx_frame_q;
        tx_cyc_d   = tx_cyc_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    tx_state_d = TX_SHIFT;
                    tx_frame_d = tx_frame_load;
                    tx_cyc_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = 1'b0;
                    tx_ready_d = 1'b0;
                end
            end
            TX_SHIFT: begin
                if (tx_cyc_q == CYC_W'(BIT_CYC - 1)) begin
                    tx_cyc_d = '0;
                    if (tx_bit_q == FB_W'(FRAME_BITS - 1)) begin
                        tx_state_d = TX_IDLE;
                        tx_d       = 1'b1;
                        tx_ready_d = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_frame_d = tx_frame_q >> 1;
                        tx_d       = tx_frame_q[1];
                    end
                end else begin
                    tx_cyc_d = tx_cyc_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_frame_q <= '1;
            tx_cyc_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_frame_q <= tx_frame_d;
            tx_cyc_q   <= tx_cyc_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign rx_s      = rx_sync_q[1];
    assign tick      = (div_q == DIV_W'(DIVISOR - 1));
    assign div_d     = tick ? '0 : div_q + 1'b1;
    // Start bit is sampled half a bit in; every later bit one full bit after that
    assign rx_at_mid = (rx_state_q == RX_START) ? (rx_phase_q == PH_W'(OVERSAMPLE / 2 - 1))
                                                : (rx_phase_q == PH_W'(OVERSAMPLE - 1));
    assign rx_sample = tick && rx_at_mid;

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_phase_d    = rx_phase_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_perr_d     = rx_perr_q;
        rx_valid_d    = 1'b0;
        rx_data_d     = rx_data_q;
        rx_perr_out_d = rx_perr_out_q;
        rx_ferr_d     = rx_ferr_q;
        if (tick && rx_state_q != RX_IDLE && rx_state_q != RX_WAIT_HIGH) begin
            rx_phase_d = rx_at_mid ? '0 : rx_phase_q + 1'b1;
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (tick && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_phase_d = '0;
                    rx_perr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (rx_sample) begin
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DB_W'(DATA_BITS - 1)) begin
                        rx_state_d = (PAR_BITS != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_perr_d  = (PARITY == 1) ? ~(rx_s ^ (^rx_shift_q)) : (rx_s ^ (^rx_shift_q));
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_valid_d    = 1'b1;
                    rx_data_d     = rx_shift_q;
                    rx_perr_out_d = rx_perr_q;
                    rx_ferr_d     = ~rx_s;
                    rx_state_d    = rx_s ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (tick && rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_q     <= 2'b11;
            div_q         <= '0;
            rx_state_q    <= RX_IDLE;
            rx_phase_q    <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_perr_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_perr_out_q <= 1'b0;
            rx_ferr_q     <= 1'b0;
        end else begin
            rx_sync_q     <= {rx_sync_q[0], rx};
            div_q         <= div_d;
            rx_state_q    <= rx_state_d;
            rx_phase_q    <= rx_phase_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_perr_q     <= rx_perr_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
            rx_perr_out_q <= rx_perr_out_d;
            rx_ferr_q     <= rx_ferr_d;
        end
    end

endmodule

// File: tb/tb_uart_duplex.sv
// Bench for uart_duplex: 8N1, 8E1 and 7O2 instances at 16 clk per bit, with a
// receive scoreboard and a table of bit-banged receive vectors.
`timescale 1ns/1ps
module tb_uart_duplex;
    localparam int unsigned BIT = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8N1: rx bit-banged by the bench
    logic [7:0] n1_tx_data, n1_rx_data;
    logic n1_tx_valid, n1_tx_ready, n1_tx, n1_bb, n1_rx_valid, n1_perr, n1_ferr;
    // 8E1: rx either looped back from its own tx or bit-banged
    logic [7:0] e1_tx_data, e1_rx_data;
    logic e1_tx_valid, e1_tx_ready, e1_tx, e1_bb, e1_loop, e1_rx, e1_rx_valid, e1_perr, e1_ferr;
    // 7O2: permanent loopback
    logic [6:0] o2_tx_data, o2_rx_data;
    logic o2_tx_valid, o2_tx_ready, o2_tx, o2_rx_valid, o2_perr, o2_ferr;

    assign e1_rx = e1_loop ? e1_tx : e1_bb;

    uart_duplex #(.DIVISOR(4), .OVERSAMPLE(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .reset(reset), .tx_data(n1_tx_data), .tx_valid(n1_tx_valid),
        .tx_ready(n1_tx_ready), .tx(n1_tx), .rx(n1_bb), .rx_data(n1_rx_data),
        .rx_valid(n1_rx_valid), .rx_parity_err(n1_perr), .rx_frame_err(n1_ferr));
    uart_duplex #(.DIVISOR(4), .OVERSAMPLE(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .clk(clk), .reset(reset), .tx_data(e1_tx_data), .tx_valid(e1_tx_valid),
        .tx_ready(e1_tx_ready), .tx(e1_tx), .rx(e1_rx), .rx_data(e1_rx_data),
        .rx_valid(e1_rx_valid), .rx_parity_err(e1_perr), .rx_frame_err(e1_ferr));
    uart_duplex #(.DIVISOR(4), .OVERSAMPLE(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_o2 (
        .clk(clk), .reset(reset), .tx_data(o2_tx_data), .tx_valid(o2_tx_valid),
        .tx_ready(o2_tx_ready), .tx(o2_tx), .rx(o2_tx), .rx_data(o2_rx_data),
        .rx_valid(o2_rx_valid), .rx_parity_err(o2_perr), .rx_frame_err(o2_ferr));

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } rx_rec_t;

    typedef struct {
        int         target;     // 1 = 8N1, 2 = 8E1
        logic [7:0] data;
        bit         glitch;     // 4-clk low pulse before the frame
        bit         flip_par;
        bit         stop_low;
        int         hold_low;   // extra bit times held low after the stop bit
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    // Capture of every rx_valid pulse, written only by this monitor
    rx_rec_t cap_n1[64], cap_e1[64], cap_o2[64];
    int wr_n1 = 0, wr_e1 = 0, wr_o2 = 0;
    always @(negedge clk) begin
        if (n1_rx_valid && wr_n1 < 64) begin
            cap_n1[wr_n1] <= '{data: 9'(n1_rx_data), perr: n1_perr, ferr: n1_ferr};
            wr_n1 <= wr_n1 + 1;
        end
        if (e1_rx_valid && wr_e1 < 64) begin
            cap_e1[wr_e1] <= '{data: 9'(e1_rx_data), perr: e1_perr, ferr: e1_ferr};
            wr_e1 <= wr_e1 + 1;
        end
        if (o2_rx_valid && wr_o2 < 64) begin
            cap_o2[wr_o2] <= '{data: 9'(o2_rx_data), perr: o2_perr, ferr: o2_ferr};
            wr_o2 <= wr_o2 + 1;
        end
    end

    int n_checks = 0, n_errs = 0;
    int rd_n1 = 0, rd_e1 = 0, rd_o2 = 0;
    rx_rec_t exp_n1[$], exp_e1[$], exp_o2[$];
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int target, input logic [8:0] d, input logic p, input logic f);
        rx_rec_t r;
        r = '{data: d, perr: p, ferr: f};
        case (target)
            1: exp_n1.push_back(r);
            2: exp_e1.push_back(r);
            default: exp_o2.push_back(r);
        endcase
    endtask

    // Compare every captured rx_valid against the scoreboard, then demand it is empty
    task automatic drain(input int target, input string tag);
        rx_rec_t g, e;
        int avail, left;
        bit have;
        avail = (target == 1) ? wr_n1 - rd_n1 : (target == 2) ? wr_e1 - rd_e1 : wr_o2 - rd_o2;
        for (int i = 0; i < avail; i++) begin
            have = 1'b0;
            case (target)
                1: begin
                    g = cap_n1[rd_n1]; rd_n1++;
                    if (exp_n1.size() > 0) begin e = exp_n1.pop_front(); have = 1'b1; end
                end
                2: begin
                    g = cap_e1[rd_e1]; rd_e1++;
                    if (exp_e1.size() > 0) begin e = exp_e1.pop_front(); have = 1'b1; end
                end
                default: begin
                    g = cap_o2[rd_o2]; rd_o2++;
                    if (exp_o2.size() > 0) begin e = exp_o2.pop_front(); have = 1'b1; end
                end
            endcase
            check({tag, " rx_valid was expected"}, 32'(have), 32'd1);
            if (have) begin
                check({tag, " rx_data"}, 32'(g.data), 32'(e.data));
                check({tag, " rx_parity_err"}, 32'(g.perr), 32'(e.perr));
                check({tag, " rx_frame_err"}, 32'(g.ferr), 32'(e.ferr));
            end
        end
        left = (target == 1) ? exp_n1.size() : (target == 2) ? exp_e1.size() : exp_o2.size();
        check({tag, " missing rx_valid count"}, 32'(left), 32'd0);
        case (target)
            1: exp_n1.delete();
            2: exp_e1.delete();
            default: exp_o2.delete();
        endcase
    endtask

    task automatic put(input int target, input logic b, input int cycles);
        if (target == 1) n1_bb = b;
        else e1_bb = b;
        step(cycles);
    endtask

    task automatic send_frame(input int target, input logic [7:0] d, input bit flip_par,
                              input bit stop_low);
        put(target, 1'b0, BIT);
        for (int i = 0; i < 8; i++) put(target, d[i], BIT);
        if (target == 2) put(target, (^d) ^ flip_par, BIT);
        put(target, ~stop_low, BIT);
    endtask

    initial begin
        logic [9:0]  fr_a5;
        logic [10:0] fr_o2;
        logic [6:0]  d7;
        int          bad, start_prev, n, d;
        vec_t        v;

        reset = 1'b1;
        n1_tx_data = '0; n1_tx_valid = 1'b0; n1_bb = 1'b1;
        e1_tx_data = '0; e1_tx_valid = 1'b0; e1_bb = 1'b1; e1_loop = 1'b0;
        o2_tx_data = '0; o2_tx_valid = 1'b0;

        vecs[0] = '{2, 8'h37, 1'b0, 1'b0, 1'b0, 0,  8'h37, 1'b0, 1'b0};
        vecs[1] = '{2, 8'h37, 1'b0, 1'b1, 1'b0, 0,  8'h37, 1'b1, 1'b0};
        vecs[2] = '{2, 8'hC3, 1'b0, 1'b0, 1'b0, 0,  8'hC3, 1'b0, 1'b0};
        vecs[3] = '{2, 8'hA0, 1'b0, 1'b0, 1'b1, 0,  8'hA0, 1'b0, 1'b1};
        vecs[4] = '{1, 8'h00, 1'b0, 1'b0, 1'b1, 40, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{1, 8'h5A, 1'b0, 1'b0, 1'b0, 0,  8'h5A, 1'b0, 1'b0};
        vecs[6] = '{1, 8'hC3, 1'b1, 1'b0, 1'b0, 0,  8'hC3, 1'b0, 1'b0};
        vecs[7] = '{1, 8'hFF, 1'b0, 1'b0, 1'b0, 0,  8'hFF, 1'b0, 1'b0};
        vecs[8] = '{2, 8'hFE, 1'b0, 1'b1, 1'b1, 0,  8'hFE, 1'b1, 1'b1};

        step(3);
        check("reset tx", 32'(n1_tx), 32'd1);
        check("reset tx_ready", 32'(n1_tx_ready), 32'd1);
        check("reset rx_valid", 32'(n1_rx_valid), 32'd0);
        check("reset rx_data", 32'(n1_rx_data), 32'd0);
        check("reset rx_parity_err", 32'(e1_perr), 32'd0);
        check("reset rx_frame_err", 32'(n1_ferr), 32'd0);
        check("reset o2 tx", 32'(o2_tx), 32'd1);
        reset = 1'b0;
        step(4);

        // 8N1 0xA5 waveform; tx_data change after accept must not leak in
        fr_a5 = {1'b1, 8'hA5, 1'b0};
        n1_tx_data = 8'hA5; n1_tx_valid = 1'b1;
        step(1);
        n1_tx_valid = 1'b0; n1_tx_data = 8'h00;
        check("A5 tx_ready after accept", 32'(n1_tx_ready), 32'd0);
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < BIT; c++) begin
                if (n1_tx !== fr_a5[b]) bad++;
                if (b == 9 && c == BIT - 1) check("A5 tx_ready in last stop cycle", 32'(n1_tx_ready), 32'd0);
                step(1);
            end
            check($sformatf("A5 bit %0d wrong cycles", b), 32'(bad), 32'd0);
        end
        check("A5 tx_ready 160 clk after accept", 32'(n1_tx_ready), 32'd1);
        check("A5 tx idle", 32'(n1_tx), 32'd1);
        step(1);
        check("A5 tx_ready stays in idle", 32'(n1_tx_ready), 32'd1);

        // 8E1 loopback of 0x37; parity bit is bit 9 of the frame
        e1_loop = 1'b1;
        e1_tx_data = 8'h37; e1_tx_valid = 1'b1;
        push_exp(2, 9'h037, 1'b0, 1'b0);
        step(1);
        e1_tx_valid = 1'b0;
        step(9 * BIT + BIT / 2);
        check("E1 transmitted parity bit", 32'(e1_tx), 32'd1);
        step(BIT / 2 + BIT + 3 * BIT);
        check("E1 tx_ready after frame", 32'(e1_tx_ready), 32'd1);
        drain(2, "E1 loopback");
        e1_loop = 1'b0;
        step(BIT);

        // Bit-banged receive vectors
        for (int k = 0; k < 9; k++) begin
            v = vecs[k];
            if (v.glitch) begin
                put(v.target, 1'b0, 4);
                put(v.target, 1'b1, 3 * BIT);
            end
            push_exp(v.target, 9'(v.exp_data), v.exp_perr, v.exp_ferr);
            send_frame(v.target, v.data, v.flip_par, v.stop_low);
            if (v.hold_low > 0) put(v.target, 1'b0, v.hold_low * BIT);
            put(v.target, 1'b1, 3 * BIT);
            drain(v.target, $sformatf("vec%0d", k));
        end

        // 7O2 back-to-back frames with tx_valid held, then reset mid-frame
        d7 = 7'h41;
        fr_o2 = {2'b11, ~(^d7), d7, 1'b0};
        o2_tx_data = d7; o2_tx_valid = 1'b1;
        start_prev = 0;
        for (int f = 0; f < 4; f++) begin
            n = 0;
            while (o2_tx !== 1'b0 && n < 400) begin
                step(1);
                n++;
            end
            check($sformatf("O2 frame %0d start seen", f), 32'(o2_tx), 32'd0);
            if (f > 0) begin
                d = cyc - start_prev;
                check($sformatf("O2 frame %0d start-to-start clk", f),
                      32'((d >= 176 && d <= 177) ? 176 : d), 32'd176);
            end
            start_prev = cyc;
            if (f < 3) begin
                push_exp(3, 9'h041, 1'b0, 1'b0);
                step(BIT / 2);
                for (int b = 0; b < 11; b++) begin
                    check($sformatf("O2 frame %0d bit %0d", f, b), 32'(o2_tx), 32'(fr_o2[b]));
                    if (b < 10) step(BIT);
                end
            end else begin
                step(50);
                reset = 1'b1;
                #1;
                check("O2 tx on reset", 32'(o2_tx), 32'd1);
                check("O2 tx_ready on reset", 32'(o2_tx_ready), 32'd1);
                o2_tx_valid = 1'b0;
                step(3);
                reset = 1'b0;
                step(400);
                check("O2 tx idle after reset", 32'(o2_tx), 32'd1);
            end
        end
        drain(3, "O2");
        drain(1, "N1 final");
        drain(2, "E1 final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
